// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the accumulator execute stage: opcodes, FSM states
// and the register-select width derivation.
package cpu_defs_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // The top entry of reg_f is the I/O port, deliberately left out of SEL range.
  function automatic int sel_w(input int size);
    return $clog2(size - 1);
  endfunction

  function automatic logic needs_read(input logic [3:0] opc);
    return (opc == OP_LD)  || (opc == OP_ADD) || (opc == OP_SUB) ||
           (opc == OP_AND) || (opc == OP_OR)  || (opc == OP_XOR);
  endfunction

endpackage

// File: rtl/exec_acc_alu.sv
// Combinational ALU for the accumulator stage: result plus carry and the
// write-enables that say which flags the operation is allowed to touch.
module alu
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             c_wr,
  output logic             z_wr
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Bit WIDTH of the difference is the borrow, set exactly when a < b.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = a;
    c_out  = 1'b0;
    c_wr   = 1'b0;
    z_wr   = 1'b0;
    case (opcode)
      OP_LDI, OP_LD: begin
        result = b;
        z_wr   = 1'b1;
      end
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c_out  = sum[WIDTH];
        c_wr   = 1'b1;
        z_wr   = 1'b1;
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c_out  = diff[WIDTH];
        c_wr   = 1'b1;
        z_wr   = 1'b1;
      end
      OP_AND: begin
        result = a & b;
        z_wr   = 1'b1;
      end
      OP_OR: begin
        result = a | b;
        z_wr   = 1'b1;
      end
      OP_XOR: begin
        result = a ^ b;
        z_wr   = 1'b1;
      end
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        c_out  = a[WIDTH-1];
        c_wr   = 1'b1;
        z_wr   = 1'b1;
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        c_out  = a[0];
        c_wr   = 1'b1;
        z_wr   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_acc.sv
// Accumulator execute stage in front of reg_f: accepts one decoded op per
// handshake, reads/writes reg_f through registered SEL/IN/EN, retires with DONE.
module exec_acc
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SIZE  = 9
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      OP_VALID,
  output logic                      OP_READY,
  input  logic [3:0]                OPCODE,
  input  logic [sel_w(SIZE)-1:0]    OP_SEL,
  input  logic [WIDTH-1:0]          OP_IMM,
  output logic [sel_w(SIZE)-1:0]    RF_SEL,
  output logic [WIDTH-1:0]          RF_IN,
  output logic                      RF_EN,
  input  logic [WIDTH-1:0]          RF_OUT,
  output logic [WIDTH-1:0]          ACC,
  output logic                      FLAG_Z,
  output logic                      FLAG_C,
  output logic                      DONE,
  output logic                      ERR
);

  state_t           state;
  logic [3:0]       opc_p0;
  logic [WIDTH-1:0] imm_p0;

  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_c_wr;
  logic             alu_z_wr;

  assign OP_READY = (state == S_IDLE);

  // reg_f OUT is only meaningful in EXEC, one clock after SEL was presented in READ.
  assign alu_b = (opc_p0 == OP_LDI) ? imm_p0 : RF_OUT;

  alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (opc_p0),
    .a      (ACC),
    .b      (alu_b),
    .result (alu_res),
    .c_out  (alu_c),
    .c_wr   (alu_c_wr),
    .z_wr   (alu_z_wr)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      opc_p0 <= OP_NOP;
      imm_p0 <= '0;
      ACC    <= '0;
      FLAG_Z <= 1'b0;
      FLAG_C <= 1'b0;
      RF_SEL <= '0;
      RF_IN  <= '0;
      RF_EN  <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      RF_EN <= 1'b0;
      case (state)
        // Accept: capture the op and present the operand index to reg_f.
        S_IDLE: begin
          if (OP_VALID) begin
            opc_p0 <= OPCODE;
            imm_p0 <= OP_IMM;
            RF_SEL <= OP_SEL;
            if (OPCODE == OP_ST) begin
              RF_IN <= ACC;
              RF_EN <= 1'b1;
              state <= S_WB;
            end else if (needs_read(OPCODE)) begin
              state <= S_READ;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        // reg_f captures OUT for RF_SEL at the end of this cycle.
        S_READ: begin
          state <= S_EXEC;
        end
        // Execute: update accumulator and the flags this opcode owns.
        S_EXEC: begin
          ACC <= alu_res;
          if (alu_c_wr) FLAG_C <= alu_c;
          if (alu_z_wr) FLAG_Z <= (alu_res == '0);
          DONE  <= 1'b1;
          ERR   <= (opc_p0 > OP_SHR);
          state <= S_IDLE;
        end
        // Write-back: reg_f writes RF_IN at the end of this cycle.
        S_WB: begin
          DONE  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
